regfile_wb_arbiter: RTL

Shares the single register-file write port between several writeback producers (ALU, load unit, CSR unit) in the rv32 core. It arbitrates among valid/ready requesters, registers the winning write onto the register-file write port, and drops writes to x0. It also keeps a 32-entry busy scoreboard that decode uses to stall on registers with an outstanding producer.

---
 rtl/regfile_wb_arbiter.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//
// Shares the single register-file write port among NREQ writeback producers
// (ALU, load unit, CSR unit, ...). One requester is granted per cycle. The
// winning write is registered onto the register-file write port one cycle
// later. Writes to x0 are accepted but never drive rf_we. A 32-entry busy
// scoreboard tracks registers that have an outstanding producer so that decode
// can stall on them.
//
// Configuration macro:
//   RF_WB_ARB_RR_EN  defined   -> round-robin arbitration with a rotating pointer
//                    undefined -> fixed priority, lowest requester index wins
//
// Parameters:
//   NREQ  number of writeback requesters (2..8)
//   XLEN  data width
//
// Ports:
//   clk        core clock; all state changes on the rising edge
//   rst_n      asynchronous assert, active-low reset
//   req_valid  [NREQ]       requester i has a write pending
//   req_ready  [NREQ]       requester i granted this cycle (combinational, one-hot or zero)
//   req_addr   [NREQ*5]     destination register of requester i in bits [5i+4:5i]
//   req_data   [NREQ*XLEN]  write data of requester i in bits [XLEN*i+XLEN-1:XLEN*i]
//   rf_we      register-file write enable
//   rf_waddr   register-file write address (holds when no write)
//   rf_wdata   register-file write data (holds when no write)
//   rsv_valid  decode reserves a destination register
//   rsv_addr   register being reserved
//   busy       bit r set = register r has an outstanding producer (bit 0 always 0)

module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*5-1:0]      req_addr,
  input  logic [NREQ*XLEN-1:0]   req_data,
  output logic                   rf_we,
  output logic [4:0]             rf_waddr,
  output logic [XLEN-1:0]        rf_wdata,
  input  logic                   rsv_valid,
  input  logic [4:0]             rsv_addr,
  output logic [31:0]            busy
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Unpacked views of the flattened request buses.
  logic [4:0]      addr_a [NREQ];
  logic [XLEN-1:0] data_a [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_a[gi] = req_addr[5*gi +: 5];
      assign data_a[gi] = req_data[XLEN*gi +: XLEN];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  logic            grant_valid;
  logic [IDXW-1:0] grant_idx;

`ifdef RF_WB_ARB_RR_EN
  logic [IDXW-1:0] ptr_q, ptr_d;

  // Search starts at ptr and wraps; the first valid requester found wins.
  always_comb begin
    int idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_valid && req_valid[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = IDXW'(idx);
      end
    end
  end

  // The pointer moves just past the winner so it becomes lowest priority next.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_valid) begin
      ptr_d = (grant_idx == IDXW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority: scanning downward leaves the lowest valid index in place.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant_valid = 1'b1;
        grant_idx   = IDXW'(i);
      end
    end
  end
`endif

  // Ready is derived from valid and arbitration state only, never from itself.
  always_comb begin
    req_ready = '0;
    if (grant_valid) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Write port register stage
  // --------------------------------------------------------------------------
  logic [4:0]      sel_addr;
  logic [XLEN-1:0] sel_data;
  logic            wr_real;

  assign sel_addr = addr_a[grant_idx];
  assign sel_data = data_a[grant_idx];
  // A granted write to x0 is consumed here and never reaches the register file.
  assign wr_real  = grant_valid && (sel_addr != 5'd0);

  logic            rf_we_q,    rf_we_d;
  logic [4:0]      rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

  always_comb begin
    rf_we_d    = wr_real;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (wr_real) begin
      rf_waddr_d = sel_addr;
      rf_wdata_d = sel_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  // --------------------------------------------------------------------------
  // Busy scoreboard
  // --------------------------------------------------------------------------
  logic [31:0] busy_q, busy_d;

  // A reservation on the same edge as a writeback to that register wins: the
  // new producer supersedes the one that is just completing. The clear uses
  // the transfer (handshake), so an x0 transfer never touches the table.
  assign busy_d[0] = 1'b0;
  generate
    for (gi = 1; gi < 32; gi++) begin : g_busy
      always_comb begin
        busy_d[gi] = busy_q[gi];
        if (rsv_valid && (rsv_addr == 5'(gi))) begin
          busy_d[gi] = 1'b1;
        end else if (grant_valid && (sel_addr == 5'(gi))) begin
          busy_d[gi] = 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule
